// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file.
//   RF_XLEN, RF_NREGS : default data width and register count
//   rf_state_t        : clear-sequencer state (CLEAR while zeroing, READY after)
//   ceil_div()        : integer ceiling division, used to size the clear sweep
package rf_pkg;

  localparam int RF_XLEN  = 32;
  localparam int RF_NREGS = 32;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_t;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/regfile_clr_seq.sv
// Clear sequencer for regfile_mp. After reset it sweeps the register array
// CLR_LANES registers per cycle, then parks in READY until the next reset.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   state      : current sequencer state (debug visibility)
//   ready      : high once the whole array has been zeroed
//   clr_en     : per-register clear strobe for the array, bit r zeroes regs[r]
//                on the next edge (entry 0 has no storage, so no bit for it)
module regfile_clr_seq
  import rf_pkg::*;
#(
  parameter int NREGS     = RF_NREGS,
  parameter int CLR_LANES = 4
) (
  input  logic             clk,
  input  logic             reset,
  output rf_state_t        state,
  output logic             ready,
  output logic [NREGS-1:1] clr_en
);

  localparam int NCLR = ceil_div(NREGS, CLR_LANES);
  localparam int CW   = (NCLR > 1) ? $clog2(NCLR) : 1;

  rf_state_t       state_nxt;
  logic [CW-1:0]   clr_cnt;
  logic [CW-1:0]   cnt_nxt;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= cnt_nxt;
    end
  end

  // Next-state logic: one chunk per cycle, leave CLEAR on the last chunk.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = clr_cnt;
    if (state == CLEAR) begin
      cnt_nxt = clr_cnt + 1'b1;
      if (clr_cnt == CW'(NCLR - 1)) begin
        state_nxt = READY;
        cnt_nxt   = clr_cnt;
      end
    end
  end

  // Outputs. ready tracks the state register directly, so it rises on the
  // same edge that clears the final chunk. Clear strobes are suppressed while
  // reset is held so the array is untouched until the sweep really starts.
  always_comb begin
    ready  = (state == READY);
    clr_en = '0;
    for (int r = 1; r < NREGS; r++) begin
      clr_en[r] = !reset && (state == CLEAR) && (clr_cnt == CW'(r / CLR_LANES));
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port integer register file with hardware clear.
// Entry 0 reads as zero and has no storage. Reads are combinational; the
// single write port commits on the rising edge once the array is READY.
// Optional build macro: REGFILE_BYPASS_EN -- forwards wd3 to any read port
// whose address matches an accepted same-cycle write.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   we3/a3/wd3 : write enable, address, data
//   ra         : packed read addresses, port i at ra[i*AW +: AW]
//   rd         : packed read data,      port i at rd[i*XLEN +: XLEN]
//   ready      : array cleared, writes accepted
module regfile_mp
  import rf_pkg::*;
#(
  parameter int XLEN      = RF_XLEN,
  parameter int NREGS     = RF_NREGS,
  parameter int NREAD     = 2,
  parameter int CLR_LANES = 4,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we3,
  input  logic [AW-1:0]         a3,
  input  logic [XLEN-1:0]       wd3,
  input  logic [NREAD*AW-1:0]   ra,
  output logic [NREAD*XLEN-1:0] rd,
  output logic                  ready
);

  rf_state_t        state;
  logic [NREGS-1:1] clr_en;
  logic             wr_req;
  logic             wr_en;

  logic [XLEN-1:0]  regs [1:NREGS-1];

  regfile_clr_seq #(
    .NREGS     (NREGS),
    .CLR_LANES (CLR_LANES)
  ) u_clr_seq (
    .clk    (clk),
    .reset  (reset),
    .state  (state),
    .ready  (ready),
    .clr_en (clr_en)
  );

  // A write is legal when READY and the address names a real, non-zero entry.
  // The range test goes through int so it stays meaningful when NREGS is a
  // power of two.
  assign wr_req = ready && we3 && (a3 != '0) && (int'(a3) < NREGS);
  assign wr_en  = wr_req && !reset;

  always_ff @(posedge clk) begin
    for (int r = 1; r < NREGS; r++) begin
      if (clr_en[r]) begin
        regs[r] <= '0;
      end else if (wr_en && (a3 == AW'(r))) begin
        regs[r] <= wd3;
      end
    end
  end

  // Read muxes: address 0 and out-of-range addresses match no entry and fall
  // through to the zero default, as does everything while in CLEAR.
  always_comb begin
    rd = '0;
    for (int p = 0; p < NREAD; p++) begin
      for (int r = 1; r < NREGS; r++) begin
        if ((state == READY) && (ra[p*AW +: AW] == AW'(r))) begin
          rd[p*XLEN +: XLEN] = regs[r];
        end
      end
`ifdef REGFILE_BYPASS_EN
      if (wr_req && (ra[p*AW +: AW] == a3)) begin
        rd[p*XLEN +: XLEN] = wd3;
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a default instance (32 regs, 2 ports, 4 lanes) and a
// 24-register, 3-port, 5-lane instance sharing the write port.
module tb_regfile_mp;

  localparam int N32  = 32;
  localparam int NC32 = (32 + 4 - 1) / 4;
  localparam int N24  = 24;
  localparam int NC24 = (24 + 5 - 1) / 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we3 = 1'b0;
  logic [4:0]  a3 = '0;
  logic [31:0] wd3 = '0;
  logic [9:0]  ra32 = '0;
  logic [63:0] rd32;
  logic        rdy32;
  logic [14:0] ra24 = '0;
  logic [95:0] rd24;
  logic        rdy24;

  int checks = 0;
  int errors = 0;

  // Reference model: register contents plus edges spent clearing.
  logic [31:0] m32 [0:31];
  logic [31:0] m24 [0:31];
  int          c32 = 0;
  int          c24 = 0;
  bit          mr32 = 1'b0;
  bit          mr24 = 1'b0;

  always #5 clk = ~clk;

  regfile_mp dut32 (
    .clk(clk), .reset(reset), .we3(we3), .a3(a3), .wd3(wd3),
    .ra(ra32), .rd(rd32), .ready(rdy32)
  );

  regfile_mp #(.XLEN(32), .NREGS(24), .NREAD(3), .CLR_LANES(5)) dut24 (
    .clk(clk), .reset(reset), .we3(we3), .a3(a3), .wd3(wd3),
    .ra(ra24), .rd(rd24), .ready(rdy24)
  );

  function automatic logic [31:0] exp_rd(input bit is24, input int addr);
    int n;
    bit rdy;
    n   = is24 ? N24 : N32;
    rdy = is24 ? mr24 : mr32;
    if (!rdy || addr == 0 || addr >= n) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (we3 && int'(a3) == addr) return wd3;
`endif
    return is24 ? m24[addr] : m32[addr];
  endfunction

  // One rising edge: apply the specification's rules to the model, then
  // leave 1ns so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      c32 = 0; c24 = 0; mr32 = 1'b0; mr24 = 1'b0;
      for (int i = 0; i < 32; i++) begin m32[i] = '0; m24[i] = '0; end
    end else begin
      if (mr32 && we3 && a3 != 0 && int'(a3) < N32) m32[a3] = wd3;
      if (mr24 && we3 && a3 != 0 && int'(a3) < N24) m24[a3] = wd3;
      if (!mr32) begin c32++; if (c32 == NC32) mr32 = 1'b1; end
      if (!mr24) begin c24++; if (c24 == NC24) mr24 = 1'b1; end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    we3 = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    ra32 = {5'd5, 5'd0};
    ra24 = {5'd23, 5'd1, 5'd0};
    #1;
    checks++;
    if (rdy32 !== 1'b0 || rdy24 !== 1'b0) begin
      errors++; $display("FAIL reset_ready got=%b/%b exp=0/0", rdy32, rdy24);
    end
    reset = 1'b0;
    for (int e = 1; e <= NC32 + 1; e++) begin
      tick();
      ra32 = {5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))};
      ra24 = {5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))};
      #1;
      checks++;
      if (rdy32 !== mr32 || rdy24 !== mr24) begin
        errors++; $display("FAIL clear_ready edge=%0d got=%b/%b exp=%b/%b", e, rdy32, rdy24, mr32, mr24);
      end
      for (int p = 0; p < 2; p++) begin
        checks++;
        if (rd32[p*32 +: 32] !== exp_rd(0, int'(ra32[p*5 +: 5]))) begin
          errors++; $display("FAIL clear_rd32 p=%0d got=%h exp=%h", p, rd32[p*32 +: 32], exp_rd(0, int'(ra32[p*5 +: 5])));
        end
      end
      for (int p = 0; p < 3; p++) begin
        checks++;
        if (rd24[p*32 +: 32] !== exp_rd(1, int'(ra24[p*5 +: 5]))) begin
          errors++; $display("FAIL clear_rd24 p=%0d got=%h exp=%h", p, rd24[p*32 +: 32], exp_rd(1, int'(ra24[p*5 +: 5])));
        end
      end
    end
  endtask

  task automatic test_write_during_clear();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    we3 = 1'b1; a3 = 5'd7; wd3 = 32'hAA;
    for (int e = 0; e < NC32; e++) tick();
    we3 = 1'b0;
    ra32 = {5'd7, 5'd7};
    ra24 = {5'd7, 5'd7, 5'd7};
    #1;
    checks++;
    if (rd32[31:0] !== 32'h0 || rd32[31:0] !== exp_rd(0, 7)) begin
      errors++; $display("FAIL clear_write_x7 got=%h exp=%h", rd32[31:0], 32'h0);
    end
    for (int p = 0; p < 3; p++) begin
      checks++;
      if (rd24[p*32 +: 32] !== exp_rd(1, 7)) begin
        errors++; $display("FAIL clear_write_x7_24 p=%0d got=%h exp=%h", p, rd24[p*32 +: 32], exp_rd(1, 7));
      end
    end
  endtask

  task automatic test_write_read();
    we3 = 1'b1; a3 = 5'd5;  wd3 = 32'hDEADBEEF; tick();
    we3 = 1'b1; a3 = 5'd31; wd3 = 32'h12345678; tick();
    we3 = 1'b0;
    ra32 = {5'd31, 5'd5};
    ra24 = {5'd0, 5'd31, 5'd5};
    #1;
    checks++;
    if (rd32 !== {32'h12345678, 32'hDEADBEEF}) begin
      errors++; $display("FAIL wr_rd32 got=%h exp=%h", rd32, {32'h12345678, 32'hDEADBEEF});
    end
    checks++;
    if (rd24 !== {exp_rd(1, 0), exp_rd(1, 31), exp_rd(1, 5)}) begin
      errors++; $display("FAIL wr_rd24 got=%h exp=%h", rd24, {exp_rd(1, 0), exp_rd(1, 31), exp_rd(1, 5)});
    end
    ra32 = {5'd5, 5'd5};
    ra24 = {5'd5, 5'd5, 5'd5};
    #1;
    checks++;
    if (rd32 !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
      errors++; $display("FAIL dup_rd32 got=%h exp=%h", rd32, {32'hDEADBEEF, 32'hDEADBEEF});
    end
    checks++;
    if (rd24 !== {3{exp_rd(1, 5)}}) begin
      errors++; $display("FAIL dup_rd24 got=%h exp=%h", rd24, {3{exp_rd(1, 5)}});
    end
  endtask

  task automatic test_x0_oor();
    we3 = 1'b1; a3 = 5'd0;  wd3 = 32'hFFFFFFFF; tick();
    we3 = 1'b1; a3 = 5'd30; wd3 = 32'h0BADF00D; tick();
    we3 = 1'b0;
    ra32 = {5'd30, 5'd0};
    ra24 = {5'd31, 5'd30, 5'd0};
    #1;
    checks++;
    if (rd32 !== {exp_rd(0, 30), 32'h0} || rd32[63:32] !== 32'h0BADF00D) begin
      errors++; $display("FAIL x0_oor32 got=%h exp=%h", rd32, {32'h0BADF00D, 32'h0});
    end
    checks++;
    if (rd24 !== 96'h0) begin
      errors++; $display("FAIL x0_oor24 got=%h exp=%h", rd24, 96'h0);
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] want;
    we3 = 1'b1; a3 = 5'd9; wd3 = 32'h1; tick();
    wd3 = 32'h2;
    ra32 = {5'd9, 5'd9};
    ra24 = {5'd9, 5'd9, 5'd9};
    #1;
`ifdef REGFILE_BYPASS_EN
    want = 32'h2;
`else
    want = 32'h1;
`endif
    checks++;
    if (rd32 !== {2{want}} || rd32 !== {2{exp_rd(0, 9)}}) begin
      errors++; $display("FAIL same_cycle32 got=%h exp=%h", rd32, {2{want}});
    end
    checks++;
    if (rd24 !== {3{exp_rd(1, 9)}}) begin
      errors++; $display("FAIL same_cycle24 got=%h exp=%h", rd24, {3{exp_rd(1, 9)}});
    end
    tick();
    we3 = 1'b0;
    #1;
    checks++;
    if (rd32 !== {2{32'h2}} || rd24 !== {3{32'h2}}) begin
      errors++; $display("FAIL after_write got=%h/%h exp=2", rd32, rd24);
    end
  endtask

  task automatic test_mid_reset();
    int edges;
    we3 = 1'b1; a3 = 5'd3; wd3 = 32'h55; tick();
    we3 = 1'b0;
    reset = 1'b1; tick();
    reset = 1'b0;
    for (int e = 0; e < 3; e++) tick();
    reset = 1'b1; tick();
    reset = 1'b0;
    edges = 0;
    while (rdy32 !== 1'b1 && edges < 20) begin
      tick();
      edges++;
      checks++;
      if (rdy32 !== mr32 || rdy24 !== mr24) begin
        errors++; $display("FAIL mid_reset_ready edge=%0d got=%b/%b exp=%b/%b", edges, rdy32, rdy24, mr32, mr24);
      end
    end
    checks++;
    if (edges != NC32) begin
      errors++; $display("FAIL mid_reset_latency got=%0d exp=%0d", edges, NC32);
    end
    ra32 = {5'd3, 5'd3};
    ra24 = {5'd3, 5'd3, 5'd3};
    #1;
    checks++;
    if (rd32 !== 64'h0 || rd24 !== 96'h0) begin
      errors++; $display("FAIL mid_reset_x3 got=%h/%h exp=0", rd32, rd24);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      we3   = 1'($urandom_range(0, 1));
      a3    = 5'($urandom_range(0, 31));
      wd3   = $urandom;
      ra32  = {5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))};
      ra24  = {5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))};
      if ($urandom_range(0, 3) == 0) ra32[4:0] = a3;
      #1;
      checks++;
      if (rdy32 !== mr32 || rdy24 !== mr24) begin
        errors++; $display("FAIL rnd_ready i=%0d got=%b/%b exp=%b/%b", i, rdy32, rdy24, mr32, mr24);
      end
      for (int p = 0; p < 2; p++) begin
        checks++;
        if (rd32[p*32 +: 32] !== exp_rd(0, int'(ra32[p*5 +: 5]))) begin
          errors++; $display("FAIL rnd_rd32 i=%0d p=%0d ra=%0d got=%h exp=%h", i, p, ra32[p*5 +: 5], rd32[p*32 +: 32], exp_rd(0, int'(ra32[p*5 +: 5])));
        end
      end
      for (int p = 0; p < 3; p++) begin
        checks++;
        if (rd24[p*32 +: 32] !== exp_rd(1, int'(ra24[p*5 +: 5]))) begin
          errors++; $display("FAIL rnd_rd24 i=%0d p=%0d ra=%0d got=%h exp=%h", i, p, ra24[p*5 +: 5], rd24[p*32 +: 32], exp_rd(1, int'(ra24[p*5 +: 5])));
        end
      end
      tick();
    end
    reset = 1'b0;
    we3 = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin m32[i] = '0; m24[i] = '0; end
    test_reset();
    test_write_during_clear();
    test_write_read();
    test_x0_oor();
    test_same_cycle();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
